// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    localparam int DEFAULT_BURST_LEN = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port between the I and D caches,
// holding a grant for up to BURST_LEN completed beats so line transfers stay contiguous.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_read,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int               CNT_W     = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    port_t            last_grant_q, last_grant_d;

    logic             req_i, req_d;
    logic             req_own, req_other;
    port_t            own_port;
    arb_state_t       grant_other;
    logic [CNT_W-1:0] beat_cnt_inc;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            last_grant_q <= PORT_I;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        own_port     = (state_q == GRANT_D) ? PORT_D : PORT_I;
        req_own      = (state_q == GRANT_D) ? req_d : req_i;
        req_other    = (state_q == GRANT_D) ? req_i : req_d;
        grant_other  = (state_q == GRANT_D) ? GRANT_I : GRANT_D;
        beat_cnt_inc = beat_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                // A tie goes to whichever port was not served last.
                if (req_i && req_d) begin
                    state_d = (last_grant_q == PORT_I) ? GRANT_D : GRANT_I;
                end else if (req_d) begin
                    state_d = GRANT_D;
                end else if (req_i) begin
                    state_d = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    if (beat_cnt_inc == BURST_MAX) begin
                        beat_cnt_d = '0;
                        if (req_other) begin
                            state_d      = grant_other;
                            last_grant_d = own_port;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_inc;
                    end
                end else if (!req_own) begin
                    beat_cnt_d   = '0;
                    last_grant_d = own_port;
                    state_d      = req_other ? grant_other : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (state_q)
            GRANT_I: begin
                mem_addr = i_addr;
                mem_read = i_read;
                i_ready  = mem_ready;
            end
            GRANT_D: begin
                // A simultaneous read and write from D resolves to the write.
                mem_addr  = d_addr;
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
            end
            default: ;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
